lsu_mem_ctrl: RTL and testbench
===============================

Name: lsu_mem_ctrl

Overview:
- Memory-side stage of the load/store unit; sits directly upstream of the data scratchpad and drives its request port.
- Accepts one load or store per transaction, issues single-cycle word requests, and waits for the scratchpad's registered mem_ready.
- Performs byte/halfword lane extraction with sign/zero extension, and read-modify-write for sub-word stores, because the scratchpad writes whole words only.
- Returns a tagged result to the writeback/commit logic.

Parameters:
- XLEN, 32, data/address width
- TAG_W, 6, ROB tag width
- TIMEOUT, 15, cycles waited for mem_ready before an error result is forced

Ports:
- clk  in  1  core clock
- reset  in  1  asynchronous, active-high reset
- req_valid  in  1  operation offered
- req_ready  out  1  controller can accept (high only in IDLE)
- req_is_store  in  1  1=store, 0=load
- req_addr  in  XLEN  byte address
- req_wdata  in  XLEN  store data, right-aligned
- req_size  in  2  00=byte, 01=half, 10=word, 11=illegal
- req_signed  in  1  sign-extend load result
- req_tag  in  TAG_W  ROB tag
- flush  in  1  squash speculative load in flight
- mem_req  out  1  scratchpad request, one-cycle pulse
- mem_we  out  1  scratchpad write enable
- mem_addr  out  XLEN  word-aligned address {addr[XLEN-1:2],2'b00}
- mem_wdata  out  XLEN  full-word write data
- mem_size  out  2  always 2'b10
- mem_atomic  out  1  tied 0
- mem_cmp_val  out  XLEN  tied 0
- mem_ready  in  1  scratchpad response valid
- mem_rdata  in  XLEN  scratchpad read word
- mem_error  in  1  scratchpad access error
- res_valid  out  1  result available
- res_ready  in  1  consumer accepts result
- res_tag  out  TAG_W  tag of completed op
- res_data  out  XLEN  load data (0 for stores)
- res_is_store  out  1  completed op was a store
- res_error  out  1  illegal size, timeout, mem_error, or misalignment

Behaviour:
- Reset (async):
  - state=IDLE
  - all outputs 0 except req_ready=1
  - latched operation discarded
  - timeout counter=0
- IDLE: req_ready=1; req_valid latches all req_* fields. Next state:
  - req_size=11: RESP with res_error=1, no memory access
  - word store: ISSUE_WR
  - any load, or sub-word store: ISSUE_RD
- ISSUE_RD: mem_req=1, mem_we=0 for exactly one cycle, then WAIT_RD.
- WAIT_RD: counter increments each cycle.
  - On mem_ready, a load: extract the lane and go to RESP.
    - byte: mem_rdata[8*off +: 8], off=addr[1:0]
    - half: mem_rdata[16*addr[1] +: 16]
    - word: mem_rdata
    - sign-extend if req_signed, else zero-extend
  - On mem_ready, a sub-word store: merge store data into the read word, register it, go to ISSUE_WR.
    - byte: req_wdata[7:0] into lane off
    - half: req_wdata[15:0] into half addr[1]
- ISSUE_WR: mem_req=1, mem_we=1, mem_wdata = merged word (or req_wdata for a word store), one cycle, then WAIT_WR.
- WAIT_WR: on mem_ready go to RESP; res_data=0, res_is_store=1.
- Errors and timeout:
  - mem_error sampled with mem_ready sets res_error=1.
  - For a sub-word store, a read error skips the write and goes straight to RESP.
  - Counter reaching TIMEOUT in WAIT_* goes to RESP with res_error=1.
  - Counter clears on every state entry.
- RESP: res_valid=1 with all res_* held stable until res_ready; the handshake cycle returns to IDLE. req_ready stays 0 in RESP, so there is no back-to-back accept in the same cycle.
- Latency (no stall), acceptance at cycle T:
  - mem_req at T+1, mem_ready at T+2, res_valid at T+3 for loads and word stores
  - sub-word store: write mem_req at T+3, res_valid at T+5
- mem_req is never high in two consecutive cycles, because the scratchpad performs one access per high cycle.
- Flush:
  - Load in ISSUE_RD/WAIT_RD/RESP: returns to IDLE next cycle with no result. A mem_ready arriving later while in IDLE is ignored.
  - Stores are non-speculative (issued at commit): flush is ignored for stores.
  - flush and req_valid in the same IDLE cycle: request not accepted.
- Address arithmetic: mem_addr low two bits are always zero; upper bits pass through with no range check (the scratchpad owns range).

Optional Feature:
- Macro: LSU_MISALIGN_CHK_EN.
- Defined: half with addr[0]=1, or word with addr[1:0]!=0, goes IDLE->RESP with res_error=1 and no memory access.
- Undefined: misaligned low bits are ignored.
  - word uses the aligned word
  - half uses addr[1] only
- No error is raised when undefined.

Test Plan:
- Word store 0xDEADBEEF to 0x100, then word load 0x100 tag 5 -> one write pulse; load res_valid at T+3, res_data=0xDEADBEEF, res_tag=5.
- Byte load addr 0x103 signed, word=0x80FF1234 -> res_data=0xFFFFFF80; unsigned -> 0x00000080.
- Byte store 0xAB to 0x101 over 0x11223344 -> read then write pulses, mem_wdata=0x1122AB44, res_valid at T+5.
- Load accepted, flush at T+1 -> no res_valid; the next load is accepted normally and returns correct data.
- mem_ready held 0 -> res_error=1 after TIMEOUT=15 cycles in WAIT_RD; req_size=11 -> immediate error, mem_req never asserted.
- res_ready held 0 for 4 cycles -> res_* stable, req_ready=0; reset asserted mid-WAIT_WR -> outputs 0, req_ready=1 immediately.

Source files
------------

// File: rtl/lsu_mem_ctrl_if.sv
// lsu_mem_ctrl_if: request, scratchpad and result buses of the LSU memory stage
interface lsu_mem_ctrl_if #(
  parameter int XLEN  = 32,
  parameter int TAG_W = 6
);
  logic             req_valid;
  logic             req_ready;
  logic             req_is_store;
  logic [XLEN-1:0]  req_addr;
  logic [XLEN-1:0]  req_wdata;
  logic [1:0]       req_size;
  logic             req_signed;
  logic [TAG_W-1:0] req_tag;
  logic             flush;
  logic             mem_req;
  logic             mem_we;
  logic [XLEN-1:0]  mem_addr;
  logic [XLEN-1:0]  mem_wdata;
  logic [1:0]       mem_size;
  logic             mem_atomic;
  logic [XLEN-1:0]  mem_cmp_val;
  logic             mem_ready;
  logic [XLEN-1:0]  mem_rdata;
  logic             mem_error;
  logic             res_valid;
  logic             res_ready;
  logic [TAG_W-1:0] res_tag;
  logic [XLEN-1:0]  res_data;
  logic             res_is_store;
  logic             res_error;
  modport slave (
    input  req_valid, req_is_store, req_addr, req_wdata, req_size, req_signed, req_tag, flush,
    input  mem_ready, mem_rdata, mem_error, res_ready,
    output req_ready, mem_req, mem_we, mem_addr, mem_wdata, mem_size, mem_atomic, mem_cmp_val,
    output res_valid, res_tag, res_data, res_is_store, res_error
  );
  modport master (
    output req_valid, req_is_store, req_addr, req_wdata, req_size, req_signed, req_tag, flush,
    output mem_ready, mem_rdata, mem_error, res_ready,
    input  req_ready, mem_req, mem_we, mem_addr, mem_wdata, mem_size, mem_atomic, mem_cmp_val,
    input  res_valid, res_tag, res_data, res_is_store, res_error
  );
endinterface

// File: rtl/lsu_mem_ctrl.sv
// lsu_mem_ctrl: LSU memory stage with lane extract and sub-word read-modify-write.
// Define LSU_MISALIGN_CHK_EN to reject misaligned half/word accesses with an error.
module lsu_mem_ctrl #(
  parameter int XLEN    = 32,
  parameter int TAG_W   = 6,
  parameter int TIMEOUT = 15
) (
  input logic clk,
  input logic reset,
  lsu_mem_ctrl_if.slave bus
);
  typedef enum logic [2:0] {IDLE, ISSUE_RD, WAIT_RD, ISSUE_WR, WAIT_WR, RESP} state_t;
  localparam int CW = $clog2(TIMEOUT + 1);
  state_t state;
  logic [CW-1:0] cnt;
  logic op_store, op_signed;
  logic [1:0] op_size, op_off;
  logic [15:0] op_wdata;
  logic [7:0] byte_v;
  logic [15:0] half_v;
  logic [XLEN-1:0] load_val, merged;
  logic accept, illegal, timeout, kill;
  assign bus.mem_size    = 2'b10;
  assign bus.mem_atomic  = 1'b0;
  assign bus.mem_cmp_val = '0;
  assign accept  = state == IDLE && bus.req_valid && !bus.flush;
  assign timeout = cnt == CW'(TIMEOUT - 1);
  assign kill    = bus.flush && !op_store;
`ifdef LSU_MISALIGN_CHK_EN
  assign illegal = &bus.req_size || (bus.req_size == 2'b01 && bus.req_addr[0]) ||
                   (bus.req_size == 2'b10 && |bus.req_addr[1:0]);
`else
  assign illegal = &bus.req_size;
`endif
  always_comb begin
    byte_v   = bus.mem_rdata[8*op_off +: 8];
    half_v   = bus.mem_rdata[16*op_off[1] +: 16];
    load_val = op_size == 2'b00 ? {{(XLEN-8){op_signed & byte_v[7]}}, byte_v} :
               op_size == 2'b01 ? {{(XLEN-16){op_signed & half_v[15]}}, half_v} : bus.mem_rdata;
    merged   = bus.mem_rdata;
    if (op_size == 2'b00) merged[8*op_off +: 8] = op_wdata[7:0];
    else merged[16*op_off[1] +: 16] = op_wdata;
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state            <= IDLE;
      cnt              <= '0;
      op_store         <= 1'b0;
      op_signed        <= 1'b0;
      op_size          <= 2'b00;
      op_off           <= 2'b00;
      op_wdata         <= '0;
      bus.req_ready    <= 1'b1;
      bus.mem_req      <= 1'b0;
      bus.mem_we       <= 1'b0;
      bus.mem_addr     <= '0;
      bus.mem_wdata    <= '0;
      bus.res_valid    <= 1'b0;
      bus.res_tag      <= '0;
      bus.res_data     <= '0;
      bus.res_is_store <= 1'b0;
      bus.res_error    <= 1'b0;
    end else begin
      bus.mem_req <= 1'b0;
      bus.mem_we  <= 1'b0;
      cnt         <= '0;
      case (state)
        IDLE: if (accept) begin
          op_store         <= bus.req_is_store;
          op_signed        <= bus.req_signed;
          op_size          <= bus.req_size;
          op_off           <= bus.req_addr[1:0];
          op_wdata         <= bus.req_wdata[15:0];
          bus.req_ready    <= 1'b0;
          bus.mem_addr     <= {bus.req_addr[XLEN-1:2], 2'b00};
          bus.mem_wdata    <= bus.req_wdata;
          bus.res_tag      <= bus.req_tag;
          bus.res_data     <= '0;
          bus.res_is_store <= bus.req_is_store;
          bus.res_error    <= illegal;
          if (illegal) begin
            state         <= RESP;
            bus.res_valid <= 1'b1;
          end else if (bus.req_is_store && bus.req_size == 2'b10) begin
            state       <= ISSUE_WR;
            bus.mem_req <= 1'b1;
            bus.mem_we  <= 1'b1;
          end else begin
            state       <= ISSUE_RD;
            bus.mem_req <= 1'b1;
          end
        end
        ISSUE_RD: begin
          state         <= kill ? IDLE : WAIT_RD;
          bus.req_ready <= kill;
        end
        WAIT_RD: if (kill) begin
          state         <= IDLE;
          bus.req_ready <= 1'b1;
        end else if (bus.mem_ready) begin
          // a sub-word store with a clean read goes on to write the merged word
          if (op_store && !bus.mem_error) begin
            state         <= ISSUE_WR;
            bus.mem_req   <= 1'b1;
            bus.mem_we    <= 1'b1;
            bus.mem_wdata <= merged;
          end else begin
            state         <= RESP;
            bus.res_valid <= 1'b1;
            bus.res_error <= bus.mem_error;
            bus.res_data  <= op_store || bus.mem_error ? '0 : load_val;
          end
        end else if (timeout) begin
          state         <= RESP;
          bus.res_valid <= 1'b1;
          bus.res_error <= 1'b1;
        end else cnt <= cnt + 1'b1;
        ISSUE_WR: state <= WAIT_WR;
        WAIT_WR: if (bus.mem_ready || timeout) begin
          state         <= RESP;
          bus.res_valid <= 1'b1;
          bus.res_error <= !bus.mem_ready || bus.mem_error;
        end else cnt <= cnt + 1'b1;
        RESP: if (kill || bus.res_ready) begin
          state         <= IDLE;
          bus.res_valid <= 1'b0;
          bus.req_ready <= 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_lsu_mem_ctrl.sv
// tb_lsu_mem_ctrl: directed checks of lsu_mem_ctrl against a one-cycle scratchpad model
module tb_lsu_mem_ctrl;
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;
  lsu_mem_ctrl_if #(.XLEN(32), .TAG_W(6)) bus();
  lsu_mem_ctrl #(.XLEN(32), .TAG_W(6), .TIMEOUT(15)) dut (.clk(clk), .reset(reset), .bus(bus));
  int n_vec = 0;
  int n_err = 0;
  logic [31:0] mem [0:255];
  logic pend = 1'b0;
  logic stall = 1'b0;
  logic err_inj = 1'b0;
  logic [31:0] rd_word = '0;
  int n_req = 0;
  int n_wr = 0;
  int n_consec = 0;

  // scratchpad: request seen in cycle N is answered with mem_ready in cycle N+1
  always @(negedge clk) begin
    bus.mem_ready = pend && !stall;
    bus.mem_rdata = pend ? rd_word : '0;
    bus.mem_error = pend && err_inj;
    if (bus.mem_req && pend) n_consec++;
    pend = bus.mem_req;
    if (bus.mem_req) begin
      n_req++;
      if (bus.mem_we) begin
        mem[bus.mem_addr[9:2]] = bus.mem_wdata;
        n_wr++;
      end else rd_word = mem[bus.mem_addr[9:2]];
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send(input logic st, input logic [31:0] a, input logic [31:0] d,
                      input logic [1:0] sz, input logic sg, input logic [5:0] tg);
    bus.req_valid = 1'b1;
    bus.req_is_store = st;
    bus.req_addr = a;
    bus.req_wdata = d;
    bus.req_size = sz;
    bus.req_signed = sg;
    bus.req_tag = tg;
    tick(1);
    bus.req_valid = 1'b0;
  endtask

  task automatic test_reset;
    bus.req_valid = 0; bus.req_is_store = 0; bus.req_addr = 0; bus.req_wdata = 0;
    bus.req_size = 0; bus.req_signed = 0; bus.req_tag = 0; bus.flush = 0; bus.res_ready = 1;
    reset = 1'b1;
    tick(2);
    n_vec++; if (bus.req_ready !== 1'b1) begin n_err++; $display("FAIL rst_req_ready got=%b exp=1", bus.req_ready); end
    n_vec++; if (bus.mem_req !== 1'b0) begin n_err++; $display("FAIL rst_mem_req got=%b exp=0", bus.mem_req); end
    n_vec++; if (bus.res_valid !== 1'b0) begin n_err++; $display("FAIL rst_res_valid got=%b exp=0", bus.res_valid); end
    n_vec++; if (bus.res_error !== 1'b0) begin n_err++; $display("FAIL rst_res_error got=%b exp=0", bus.res_error); end
    n_vec++; if (bus.mem_addr !== 32'h0) begin n_err++; $display("FAIL rst_mem_addr got=%h exp=0", bus.mem_addr); end
    n_vec++; if (bus.mem_size !== 2'b10) begin n_err++; $display("FAIL rst_mem_size got=%b exp=10", bus.mem_size); end
    reset = 1'b0;
    tick(1);
  endtask

  task automatic test_word;
    int w0;
    w0 = n_wr;
    send(1, 32'h100, 32'hDEADBEEF, 2'b10, 0, 6'd3);
    n_vec++; if (bus.mem_req !== 1'b1 || bus.mem_we !== 1'b1) begin n_err++; $display("FAIL wst_pulse got=%b%b exp=11", bus.mem_req, bus.mem_we); end
    n_vec++; if (bus.mem_addr !== 32'h100) begin n_err++; $display("FAIL wst_addr got=%h exp=100", bus.mem_addr); end
    n_vec++; if (bus.mem_wdata !== 32'hDEADBEEF) begin n_err++; $display("FAIL wst_wdata got=%h exp=deadbeef", bus.mem_wdata); end
    tick(1);
    n_vec++; if (bus.mem_req !== 1'b0) begin n_err++; $display("FAIL wst_req_drop got=%b exp=0", bus.mem_req); end
    tick(1);
    n_vec++; if (bus.res_valid !== 1'b1 || bus.res_is_store !== 1'b1 || bus.res_tag !== 6'd3) begin n_err++; $display("FAIL wst_res got=%b%b/%0d exp=11/3", bus.res_valid, bus.res_is_store, bus.res_tag); end
    n_vec++; if (bus.req_ready !== 1'b0) begin n_err++; $display("FAIL wst_resp_req_ready got=%b exp=0", bus.req_ready); end
    tick(1);
    n_vec++; if (n_wr !== w0 + 1 || mem[64] !== 32'hDEADBEEF) begin n_err++; $display("FAIL wst_mem got=%0d/%h exp=%0d/deadbeef", n_wr, mem[64], w0 + 1); end
    send(0, 32'h100, 32'h0, 2'b10, 0, 6'd5);
    tick(1);
    n_vec++; if (bus.res_valid !== 1'b0) begin n_err++; $display("FAIL wld_early got=%b exp=0", bus.res_valid); end
    tick(1);
    n_vec++; if (bus.res_valid !== 1'b1 || bus.res_data !== 32'hDEADBEEF) begin n_err++; $display("FAIL wld_data got=%b/%h exp=1/deadbeef", bus.res_valid, bus.res_data); end
    n_vec++; if (bus.res_tag !== 6'd5 || bus.res_is_store !== 1'b0) begin n_err++; $display("FAIL wld_tag got=%0d/%b exp=5/0", bus.res_tag, bus.res_is_store); end
    tick(1);
  endtask

  task automatic test_lane_load;
    logic [31:0] addrs [6];
    logic [1:0]  sizes [6];
    logic        sgns  [6];
    logic [31:0] exps  [6];
    addrs = '{32'h203, 32'h203, 32'h201, 32'h202, 32'h200, 32'h202};
    sizes = '{2'b00, 2'b00, 2'b00, 2'b01, 2'b01, 2'b01};
    sgns  = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
    exps  = '{32'hFFFFFF80, 32'h00000080, 32'h00000012, 32'hFFFF80FF, 32'h00001234, 32'h000080FF};
    mem[128] = 32'h80FF1234;
    for (int i = 0; i < 6; i++) begin
      send(0, addrs[i], 32'h0, sizes[i], sgns[i], 6'(i));
      tick(2);
      n_vec++; if (bus.res_valid !== 1'b1 || bus.res_data !== exps[i]) begin n_err++; $display("FAIL lane_%0d got=%b/%h exp=1/%h", i, bus.res_valid, bus.res_data, exps[i]); end
      tick(1);
    end
  endtask

  task automatic test_misalign;
    send(0, 32'h202, 32'h0, 2'b10, 0, 6'd15);
`ifdef LSU_MISALIGN_CHK_EN
    n_vec++; if (bus.res_valid !== 1'b1 || bus.res_error !== 1'b1 || bus.mem_req !== 1'b0) begin n_err++; $display("FAIL misalign_err got=%b%b%b exp=110", bus.res_valid, bus.res_error, bus.mem_req); end
    tick(1);
`else
    tick(2);
    n_vec++; if (bus.res_valid !== 1'b1 || bus.res_error !== 1'b0 || bus.res_data !== 32'h80FF1234) begin n_err++; $display("FAIL misalign_word got=%b%b/%h exp=10/80ff1234", bus.res_valid, bus.res_error, bus.res_data); end
    tick(1);
`endif
  endtask

  task automatic test_subword_store;
    int w0;
    w0 = n_wr;
    mem[80] = 32'h11223344;
    send(1, 32'h141, 32'hFFFFFFAB, 2'b00, 0, 6'd6);
    n_vec++; if (bus.mem_req !== 1'b1 || bus.mem_we !== 1'b0) begin n_err++; $display("FAIL rmw_rd got=%b%b exp=10", bus.mem_req, bus.mem_we); end
    tick(1);
    n_vec++; if (bus.mem_req !== 1'b0) begin n_err++; $display("FAIL rmw_gap got=%b exp=0", bus.mem_req); end
    tick(1);
    n_vec++; if (bus.mem_req !== 1'b1 || bus.mem_we !== 1'b1 || bus.mem_wdata !== 32'h1122AB44) begin n_err++; $display("FAIL rmw_wr got=%b%b/%h exp=11/1122ab44", bus.mem_req, bus.mem_we, bus.mem_wdata); end
    tick(1);
    n_vec++; if (bus.res_valid !== 1'b0) begin n_err++; $display("FAIL rmw_early got=%b exp=0", bus.res_valid); end
    tick(1);
    n_vec++; if (bus.res_valid !== 1'b1 || bus.res_is_store !== 1'b1 || bus.res_data !== 32'h0) begin n_err++; $display("FAIL rmw_res got=%b%b/%h exp=11/0", bus.res_valid, bus.res_is_store, bus.res_data); end
    tick(1);
    send(1, 32'h142, 32'h0000BEEF, 2'b01, 0, 6'd7);
    tick(4);
    n_vec++; if (bus.res_valid !== 1'b1) begin n_err++; $display("FAIL rmw_half_res got=%b exp=1", bus.res_valid); end
    tick(1);
    n_vec++; if (mem[80] !== 32'hBEEFAB44 || n_wr !== w0 + 2) begin n_err++; $display("FAIL rmw_half_mem got=%h/%0d exp=beefab44/%0d", mem[80], n_wr, w0 + 2); end
  endtask

  task automatic test_mem_error;
    int w0;
    w0 = n_wr;
    mem[112] = 32'h55667788;
    err_inj = 1'b1;
    send(1, 32'h1C1, 32'h0000005A, 2'b00, 0, 6'd8);
    tick(2);
    n_vec++; if (bus.res_valid !== 1'b1 || bus.res_error !== 1'b1 || bus.res_is_store !== 1'b1) begin n_err++; $display("FAIL merr_res got=%b%b%b exp=111", bus.res_valid, bus.res_error, bus.res_is_store); end
    tick(1);
    err_inj = 1'b0;
    n_vec++; if (n_wr !== w0 || mem[112] !== 32'h55667788) begin n_err++; $display("FAIL merr_nowrite got=%0d/%h exp=%0d/55667788", n_wr, mem[112], w0); end
  endtask

  task automatic test_flush;
    logic seen;
    send(0, 32'h200, 32'h0, 2'b10, 0, 6'd10);
    bus.flush = 1'b1;
    tick(1);
    bus.flush = 1'b0;
    n_vec++; if (bus.req_ready !== 1'b1 || bus.mem_req !== 1'b0) begin n_err++; $display("FAIL flush_idle got=%b%b exp=10", bus.req_ready, bus.mem_req); end
    seen = 1'b0;
    repeat (4) begin
      seen |= bus.res_valid;
      tick(1);
    end
    n_vec++; if (seen !== 1'b0) begin n_err++; $display("FAIL flush_nores got=%b exp=0", seen); end
    bus.flush = 1'b1;
    send(0, 32'h200, 32'h0, 2'b10, 0, 6'd9);
    bus.flush = 1'b0;
    n_vec++; if (bus.mem_req !== 1'b0 || bus.req_ready !== 1'b1) begin n_err++; $display("FAIL flush_noaccept got=%b%b exp=01", bus.mem_req, bus.req_ready); end
    send(0, 32'h200, 32'h0, 2'b10, 0, 6'd11);
    tick(2);
    n_vec++; if (bus.res_valid !== 1'b1 || bus.res_data !== 32'h80FF1234 || bus.res_tag !== 6'd11) begin n_err++; $display("FAIL flush_next got=%b/%h/%0d exp=1/80ff1234/11", bus.res_valid, bus.res_data, bus.res_tag); end
    tick(1);
    send(1, 32'h1C1, 32'h0000005A, 2'b00, 0, 6'd12);
    bus.flush = 1'b1;
    tick(4);
    n_vec++; if (bus.res_valid !== 1'b1 || bus.res_is_store !== 1'b1) begin n_err++; $display("FAIL flush_store got=%b%b exp=11", bus.res_valid, bus.res_is_store); end
    bus.flush = 1'b0;
    tick(1);
    n_vec++; if (mem[112] !== 32'h55665A88) begin n_err++; $display("FAIL flush_store_mem got=%h exp=55665a88", mem[112]); end
    bus.res_ready = 1'b0;
    send(0, 32'h200, 32'h0, 2'b10, 0, 6'd13);
    tick(2);
    bus.flush = 1'b1;
    tick(1);
    bus.flush = 1'b0;
    bus.res_ready = 1'b1;
    n_vec++; if (bus.res_valid !== 1'b0 || bus.req_ready !== 1'b1) begin n_err++; $display("FAIL flush_resp got=%b%b exp=01", bus.res_valid, bus.req_ready); end
  endtask

  task automatic test_timeout;
    logic early;
    int r0;
    stall = 1'b1;
    send(0, 32'h200, 32'h0, 2'b10, 0, 6'd13);
    early = 1'b0;
    repeat (16) begin
      early |= bus.res_valid;
      tick(1);
    end
    n_vec++; if (early !== 1'b0) begin n_err++; $display("FAIL tmo_early got=%b exp=0", early); end
    n_vec++; if (bus.res_valid !== 1'b1 || bus.res_error !== 1'b1 || bus.res_tag !== 6'd13) begin n_err++; $display("FAIL tmo_res got=%b%b/%0d exp=11/13", bus.res_valid, bus.res_error, bus.res_tag); end
    stall = 1'b0;
    tick(1);
    r0 = n_req;
    send(0, 32'h200, 32'h0, 2'b11, 0, 6'd14);
    n_vec++; if (bus.res_valid !== 1'b1 || bus.res_error !== 1'b1 || bus.mem_req !== 1'b0) begin n_err++; $display("FAIL illegal_res got=%b%b%b exp=110", bus.res_valid, bus.res_error, bus.mem_req); end
    tick(1);
    n_vec++; if (n_req !== r0) begin n_err++; $display("FAIL illegal_noreq got=%0d exp=%0d", n_req, r0); end
  endtask

  task automatic test_resp_hold;
    bus.res_ready = 1'b0;
    send(0, 32'h200, 32'h0, 2'b10, 0, 6'd20);
    tick(2);
    repeat (4) begin
      n_vec++; if (bus.res_valid !== 1'b1 || bus.res_data !== 32'h80FF1234 || bus.res_tag !== 6'd20) begin n_err++; $display("FAIL hold_res got=%b/%h/%0d exp=1/80ff1234/20", bus.res_valid, bus.res_data, bus.res_tag); end
      n_vec++; if (bus.req_ready !== 1'b0) begin n_err++; $display("FAIL hold_req_ready got=%b exp=0", bus.req_ready); end
      tick(1);
    end
    bus.res_ready = 1'b1;
    tick(1);
    n_vec++; if (bus.res_valid !== 1'b0 || bus.req_ready !== 1'b1) begin n_err++; $display("FAIL hold_release got=%b%b exp=01", bus.res_valid, bus.req_ready); end
  endtask

  task automatic test_reset_mid;
    stall = 1'b1;
    send(1, 32'h180, 32'h12345678, 2'b10, 0, 6'd21);
    tick(2);
    #2 reset = 1'b1;
    #1;
    n_vec++; if (bus.req_ready !== 1'b1 || bus.mem_req !== 1'b0 || bus.res_valid !== 1'b0) begin n_err++; $display("FAIL rstmid_ctl got=%b%b%b exp=100", bus.req_ready, bus.mem_req, bus.res_valid); end
    n_vec++; if (bus.mem_wdata !== 32'h0 || bus.mem_addr !== 32'h0) begin n_err++; $display("FAIL rstmid_data got=%h/%h exp=0/0", bus.mem_wdata, bus.mem_addr); end
    reset = 1'b0;
    stall = 1'b0;
    tick(1);
  endtask

  task automatic test_back_to_back;
    bus.req_is_store = 0; bus.req_addr = 32'h200; bus.req_size = 2'b10; bus.req_signed = 0; bus.req_tag = 6'd30;
    bus.req_valid = 1'b1;
    tick(3);
    n_vec++; if (bus.res_valid !== 1'b1 || bus.res_tag !== 6'd30 || bus.req_ready !== 1'b0) begin n_err++; $display("FAIL b2b_first got=%b/%0d/%b exp=1/30/0", bus.res_valid, bus.res_tag, bus.req_ready); end
    bus.req_tag = 6'd31;
    tick(1);
    n_vec++; if (bus.req_ready !== 1'b1 || bus.mem_req !== 1'b0) begin n_err++; $display("FAIL b2b_idle got=%b%b exp=10", bus.req_ready, bus.mem_req); end
    tick(1);
    bus.req_valid = 1'b0;
    n_vec++; if (bus.mem_req !== 1'b1) begin n_err++; $display("FAIL b2b_second_req got=%b exp=1", bus.mem_req); end
    tick(2);
    n_vec++; if (bus.res_valid !== 1'b1 || bus.res_tag !== 6'd31 || bus.res_data !== 32'h80FF1234) begin n_err++; $display("FAIL b2b_second got=%b/%0d/%h exp=1/31/80ff1234", bus.res_valid, bus.res_tag, bus.res_data); end
    tick(1);
    n_vec++; if (n_consec !== 0) begin n_err++; $display("FAIL consec_mem_req got=%0d exp=0", n_consec); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    test_reset;
    test_word;
    test_lane_load;
    test_misalign;
    test_subword_store;
    test_mem_error;
    test_flush;
    test_timeout;
    test_resp_hold;
    test_reset_mid;
    test_back_to_back;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
